// File: rtl/transport_ctrl_if.sv
// Button/switch inputs and transport outputs shared between the front end
// (master) and the playback transport controller (slave).
interface transport_ctrl_if #(
  parameter int SONG_W = 2
);
  logic              play_button;
  logic              next_button;
  logic              prev_button;
  logic              ff_switch0;
  logic              r_switch1;
  logic              song_done;
  logic [SONG_W-1:0] current_song;
  logic              play;
  logic              beat;
  logic              reverse;
  logic              song_start;

  modport master (
    output play_button, next_button, prev_button, ff_switch0, r_switch1, song_done,
    input  current_song, play, beat, reverse, song_start
  );

  modport slave (
    input  play_button, next_button, prev_button, ff_switch0, r_switch1, song_done,
    output current_song, play, beat, reverse, song_start
  );
endinterface

// File: rtl/transport_ctrl.sv
// Playback transport: song selection, play/pause, fast/reverse beat strobe.
// Define AUTO_ADVANCE_EN to make a forward end-of-song advance and keep playing.
module transport_ctrl #(
  parameter int NUM_SONGS  = 4,
  parameter int SONG_W     = 2,
  parameter int BEAT_COUNT = 1000,
  parameter int FF_STEP    = 2
) (
  input logic             clk,
  input logic             reset,
  transport_ctrl_if.slave io_bus
);

  typedef enum logic [1:0] {
    PAUSED,
    PLAYING,
    SWITCH
  } state_t;

  localparam int                CNT_W     = $clog2(BEAT_COUNT + FF_STEP);
  localparam logic [SONG_W-1:0] LAST_SONG = SONG_W'(NUM_SONGS - 1);
  localparam logic [CNT_W-1:0]  BEAT_LIM  = CNT_W'(BEAT_COUNT);
  localparam logic [CNT_W-1:0]  FAST_STEP = CNT_W'(FF_STEP);

  state_t            r_state;
  state_t            w_nextState;
  logic [SONG_W-1:0] r_song;
  logic [SONG_W-1:0] w_nextSong;
  logic [SONG_W-1:0] w_songUp;
  logic [SONG_W-1:0] w_songDown;
  logic              r_resumePlay;
  logic              w_nextResume;
  logic              w_songStart;
  logic              w_nextPlay;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_step;
  logic [CNT_W-1:0]  w_sum;
  logic              r_play;
  logic              r_beat;
  logic              r_reverse;
  logic              r_songStart;

  assign w_songUp   = (r_song == LAST_SONG) ? '0 : r_song + SONG_W'(1);
  assign w_songDown = (r_song == '0) ? LAST_SONG : r_song - SONG_W'(1);
  assign w_step     = io_bus.ff_switch0 ? FAST_STEP : CNT_W'(1);
  assign w_sum      = r_cnt + w_step;

  // Event priority: next, prev, song_done (PLAYING only), play.
  always_comb begin
    w_nextState  = r_state;
    w_nextSong   = r_song;
    w_nextResume = r_resumePlay;
    w_songStart  = 1'b0;
    case (r_state)
      SWITCH: begin
        w_nextState  = r_resumePlay ? PLAYING : PAUSED;
        w_nextResume = 1'b0;
      end
      default: begin
        if (io_bus.next_button) begin
          w_nextSong   = w_songUp;
          w_nextState  = SWITCH;
          w_songStart  = 1'b1;
          w_nextResume = 1'b0;
        end else if (io_bus.prev_button) begin
          w_nextSong   = w_songDown;
          w_nextState  = SWITCH;
          w_songStart  = 1'b1;
          w_nextResume = 1'b0;
        end else if (io_bus.song_done && (r_state == PLAYING)) begin
          if (r_reverse) begin
            w_nextState = PAUSED;
          end else begin
`ifdef AUTO_ADVANCE_EN
            w_nextSong   = w_songUp;
            w_nextResume = 1'b1;
`else
            w_nextResume = 1'b0;
`endif
            w_nextState = SWITCH;
            w_songStart = 1'b1;
          end
        end else if (io_bus.play_button) begin
          w_nextState = (r_state == PLAYING) ? PAUSED : PLAYING;
        end
      end
    endcase
    w_nextPlay = (w_nextState == PLAYING) || ((w_nextState == SWITCH) && w_nextResume);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= PAUSED;
      r_song       <= '0;
      r_resumePlay <= 1'b0;
      r_songStart  <= 1'b0;
      r_play       <= 1'b0;
      r_reverse    <= 1'b0;
    end else begin
      r_state      <= w_nextState;
      r_song       <= w_nextSong;
      r_resumePlay <= w_nextResume;
      r_songStart  <= w_songStart;
      r_play       <= w_nextPlay;
      r_reverse    <= io_bus.r_switch1;
    end
  end

  // The counter advances on each edge into a PLAYING cycle, so the remainder
  // carries across beats and across pauses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_beat <= 1'b0;
    end else if (w_nextState == SWITCH) begin
      r_cnt  <= '0;
      r_beat <= 1'b0;
    end else if (w_nextState == PLAYING) begin
      if (w_sum >= BEAT_LIM) begin
        r_cnt  <= w_sum - BEAT_LIM;
        r_beat <= 1'b1;
      end else begin
        r_cnt  <= w_sum;
        r_beat <= 1'b0;
      end
    end else begin
      r_beat <= 1'b0;
    end
  end

  assign io_bus.current_song = r_song;
  assign io_bus.play         = r_play;
  assign io_bus.beat         = r_beat;
  assign io_bus.reverse      = r_reverse;
  assign io_bus.song_start   = r_songStart;

endmodule

// File: tb/tb_transport_ctrl.sv
// Bench for transport_ctrl: two instances (BEAT_COUNT 100 and 101) share stimulus
// and are checked every cycle against a progress-based model; honours AUTO_ADVANCE_EN.
module tb_transport_ctrl;

  localparam int NUM_SONGS = 4;
  localparam int SONG_W    = 2;
  localparam int FF_STEP   = 2;
  localparam int BC_A      = 100;
  localparam int BC_B      = 101;

  logic clk      = 1'b0;
  logic reset    = 1'b0;
  logic playBtn  = 1'b0;
  logic nextBtn  = 1'b0;
  logic prevBtn  = 1'b0;
  logic ffSw     = 1'b0;
  logic revSw    = 1'b0;
  logic songDone = 1'b0;
  bit   checkEn  = 1'b0;
  int   total    = 0;
  int   bad      = 0;

  always #5 clk = ~clk;

  transport_ctrl_if #(.SONG_W(SONG_W)) ifA ();
  transport_ctrl_if #(.SONG_W(SONG_W)) ifB ();

  assign ifA.play_button = playBtn;
  assign ifA.next_button = nextBtn;
  assign ifA.prev_button = prevBtn;
  assign ifA.ff_switch0  = ffSw;
  assign ifA.r_switch1   = revSw;
  assign ifA.song_done   = songDone;
  assign ifB.play_button = playBtn;
  assign ifB.next_button = nextBtn;
  assign ifB.prev_button = prevBtn;
  assign ifB.ff_switch0  = ffSw;
  assign ifB.r_switch1   = revSw;
  assign ifB.song_done   = songDone;

  transport_ctrl #(.NUM_SONGS(NUM_SONGS), .SONG_W(SONG_W), .BEAT_COUNT(BC_A), .FF_STEP(FF_STEP))
    dutA (.clk(clk), .reset(reset), .io_bus(ifA));
  transport_ctrl #(.NUM_SONGS(NUM_SONGS), .SONG_W(SONG_W), .BEAT_COUNT(BC_B), .FF_STEP(FF_STEP))
    dutB (.clk(clk), .reset(reset), .io_bus(ifB));

  // Model: mode 0 paused, 1 playing, 2 switching; a beat occurs whenever the
  // accumulated play progress crosses a multiple of the beat length.
  typedef struct {
    int mode;
    int song;
    int progress;
    bit play;
    bit beat;
    bit rev;
    bit start;
    bit ret;
  } model_t;

  model_t mA;
  model_t mB;

  function automatic model_t modelReset();
    model_t m;
    m.mode = 0; m.song = 0; m.progress = 0; m.play = 0;
    m.beat = 0; m.rev = 0; m.start = 0; m.ret = 0;
    return m;
  endfunction

  function automatic model_t modelStep(model_t m, int bc);
    model_t n = m;
    int step = ffSw ? FF_STEP : 1;
    n.start = 0;
    n.rev   = revSw;
    if (m.mode == 2) begin
      n.mode = m.ret ? 1 : 0;
      n.ret  = 0;
    end else if (nextBtn) begin
      n.song = (m.song + 1) % NUM_SONGS; n.mode = 2; n.start = 1; n.ret = 0;
    end else if (prevBtn) begin
      n.song = (m.song + NUM_SONGS - 1) % NUM_SONGS; n.mode = 2; n.start = 1; n.ret = 0;
    end else if (songDone && m.mode == 1) begin
      if (m.rev) begin
        n.mode = 0;
      end else begin
`ifdef AUTO_ADVANCE_EN
        n.song = (m.song + 1) % NUM_SONGS;
        n.ret  = 1;
`endif
        n.mode  = 2;
        n.start = 1;
      end
    end else if (playBtn) begin
      n.mode = (m.mode == 1) ? 0 : 1;
    end
    n.play = (n.mode == 1) || (n.mode == 2 && n.ret);
    n.beat = 0;
    if (n.mode == 2) begin
      n.progress = 0;
    end else if (n.mode == 1) begin
      n.progress = m.progress + step;
      n.beat     = (n.progress / bc) != (m.progress / bc);
    end
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mA <= modelReset();
      mB <= modelReset();
    end else begin
      mA <= modelStep(mA, BC_A);
      mB <= modelStep(mB, BC_B);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("A.song",  32'(ifA.current_song), 32'(mA.song));
      checkOutput("A.play",  32'(ifA.play),         32'(mA.play));
      checkOutput("A.beat",  32'(ifA.beat),         32'(mA.beat));
      checkOutput("A.rev",   32'(ifA.reverse),      32'(mA.rev));
      checkOutput("A.start", 32'(ifA.song_start),   32'(mA.start));
      checkOutput("B.song",  32'(ifB.current_song), 32'(mB.song));
      checkOutput("B.play",  32'(ifB.play),         32'(mB.play));
      checkOutput("B.beat",  32'(ifB.beat),         32'(mB.beat));
      checkOutput("B.rev",   32'(ifB.reverse),      32'(mB.rev));
      checkOutput("B.start", 32'(ifB.song_start),   32'(mB.start));
    end
  end

  // Drives one-cycle pulses; returns at the falling edge of the cycle after sampling.
  task automatic applyStimulus(input bit nxt, input bit prv, input bit done, input bit ply,
                               input bit waitFirst);
    if (waitFirst) @(negedge clk);
    nextBtn  = nxt;
    prevBtn  = prv;
    songDone = done;
    playBtn  = ply;
    @(negedge clk);
    nextBtn  = 1'b0;
    prevBtn  = 1'b0;
    songDone = 1'b0;
    playBtn  = 1'b0;
  endtask

  initial begin
    int beatAt[$];
    int aBeats[$];
    int bBeats[$];
    int expSong[4];
    int diffA, diffB1, diffB2, sawBeat, beatJ;
    expSong = '{1, 2, 3, 0};

    #1 reset = 1'b1;
    checkEn = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset song",  32'(ifA.current_song), 0);
    checkOutput("reset play",  32'(ifA.play), 0);
    checkOutput("reset beat",  32'(ifA.beat), 0);
    checkOutput("reset rev",   32'(ifA.reverse), 0);
    checkOutput("reset start", 32'(ifA.song_start), 0);
    reset = 1'b0;

    $display("[TB] play and normal-speed beats");
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("play after press", 32'(ifA.play), 1);
    for (int k = 1; k <= 300; k++) begin
      if (k > 1) @(negedge clk);
      if (ifA.beat === 1'b1) beatAt.push_back(k);
    end
    checkOutput("beat count in 300", beatAt.size(), 3);
    for (int i = 0; i < 3; i++)
      checkOutput($sformatf("beat %0d cycle", i), (i < beatAt.size()) ? beatAt[i] : -1, (i + 1) * 100);
    checkOutput("song still 0", 32'(ifA.current_song), 0);

    $display("[TB] fast-forward");
    ffSw = 1'b1;
    for (int j = 1; j <= 260; j++) begin
      @(negedge clk);
      if (ifA.beat === 1'b1) aBeats.push_back(j);
      if (ifB.beat === 1'b1) bBeats.push_back(j);
    end
    ffSw = 1'b0;
    diffA  = (aBeats.size() >= 2) ? aBeats[$] - aBeats[$-1] : -1;
    diffB1 = (bBeats.size() >= 3) ? bBeats[$] - bBeats[$-1] : -1;
    diffB2 = (bBeats.size() >= 3) ? bBeats[$-1] - bBeats[$-2] : -1;
    checkOutput("ff period 100", diffA, 50);
    checkOutput("ff period 101 last", diffB1, 50);
    checkOutput("ff period 101 prev", diffB2, 51);

    $display("[TB] song selection");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, 0, 0, 1);
      checkOutput("next song", 32'(ifA.current_song), expSong[i]);
      checkOutput("next start", 32'(ifA.song_start), 1);
      checkOutput("next play", 32'(ifA.play), 0);
      @(negedge clk);
      checkOutput("next start drop", 32'(ifA.song_start), 0);
    end
    applyStimulus(0, 1, 0, 0, 1);
    checkOutput("prev wrap", 32'(ifA.current_song), 3);
    checkOutput("prev start", 32'(ifA.song_start), 1);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("next ignored in switch", 32'(ifA.current_song), 3);
    checkOutput("no start after ignore", 32'(ifA.song_start), 0);

    $display("[TB] pause and resume");
    applyStimulus(0, 0, 0, 1, 1);
    sawBeat = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) @(negedge clk);
      if (ifA.beat === 1'b1) sawBeat++;
    end
    checkOutput("no early beat", sawBeat, 0);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("paused", 32'(ifA.play), 0);
    repeat (500) @(negedge clk);
    checkOutput("still paused", 32'(ifA.play), 0);
    applyStimulus(0, 0, 0, 1, 0);
    beatJ = -1;
    for (int j = 1; j <= 200; j++) begin
      if (j > 1) @(negedge clk);
      if (ifA.beat === 1'b1) begin
        beatJ = j;
        break;
      end
    end
    checkOutput("beat after resume", beatJ, 60);

    $display("[TB] next beats play");
    applyStimulus(1, 0, 0, 1, 1);
    checkOutput("tie song", 32'(ifA.current_song), 0);
    checkOutput("tie start", 32'(ifA.song_start), 1);
    checkOutput("tie play", 32'(ifA.play), 0);
    repeat (3) @(negedge clk);
    checkOutput("tie paused", 32'(ifA.play), 0);

    $display("[TB] forward song_done");
    applyStimulus(0, 1, 0, 0, 1);
    applyStimulus(0, 0, 0, 1, 1);
    repeat (5) @(negedge clk);
    applyStimulus(0, 0, 1, 0, 1);
    checkOutput("done start", 32'(ifA.song_start), 1);
`ifdef AUTO_ADVANCE_EN
    checkOutput("done song", 32'(ifA.current_song), 0);
    checkOutput("done play", 32'(ifA.play), 1);
    checkOutput("done beat", 32'(ifA.beat), 0);
    @(negedge clk);
    checkOutput("done play after", 32'(ifA.play), 1);
`else
    checkOutput("done song", 32'(ifA.current_song), 3);
    checkOutput("done play", 32'(ifA.play), 0);
    @(negedge clk);
    checkOutput("done play after", 32'(ifA.play), 0);
`endif
    checkOutput("done start drop", 32'(ifA.song_start), 0);

    $display("[TB] reverse song_done");
    revSw = 1'b1;
    @(negedge clk);
    checkOutput("reverse out", 32'(ifA.reverse), 1);
`ifndef AUTO_ADVANCE_EN
    applyStimulus(0, 0, 0, 1, 1);
`endif
    repeat (3) @(negedge clk);
    applyStimulus(0, 0, 1, 0, 1);
    checkOutput("rev done play", 32'(ifA.play), 0);
    checkOutput("rev done start", 32'(ifA.song_start), 0);
`ifdef AUTO_ADVANCE_EN
    checkOutput("rev done song", 32'(ifA.current_song), 0);
`else
    checkOutput("rev done song", 32'(ifA.current_song), 3);
`endif

    $display("[TB] reset during switch");
    revSw = 1'b0;
    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("pre-reset start", 32'(ifA.song_start), 1);
    #2 reset = 1'b1;
    #1;
    checkOutput("async reset song", 32'(ifA.current_song), 0);
    checkOutput("async reset start", 32'(ifA.song_start), 0);
    checkOutput("async reset play", 32'(ifA.play), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    checkEn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
